shift_issue_queue: RTL and testbench

// - Operand staging and result-capture stage wrapped around the 8-bit combinational logical-right barrel shifter.
// - Buffers {data, amount} requests in a small FIFO and presents the FIFO head to the shifter.
// - Registers the shifter result into a valid/ready output slot.
// - Decouples the bursty upstream producer from the downstream consumer; the shifter itself stays purely combinational.

---
 rtl/shift_pkg.sv | 10 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/shift_issue_queue.sv | 68 ++++++
 tb/tb_shift_issue_queue.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared widths and the request record staged ahead of the shifter.
package shift_pkg;
   localparam int DATA_W = 8;
   localparam int AMT_W  = 3;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
   } shift_req_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; flush clears pointers and count
// and outranks push/pop.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [WIDTH-1:0]             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/shift_issue_queue.sv
// Request FIFO in front of an external combinational right shifter, with
// a registered valid/ready result slot behind it.
module shift_issue_queue
   import shift_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic [AMT_W-1:0]             in_amt,
   output logic [DATA_W-1:0]            sh_a,
   output logic [AMT_W-1:0]             sh_b,
   input  logic [DATA_W-1:0]            sh_o,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   shift_req_t wr_req;
   shift_req_t head_req;
   logic       full;
   logic       empty;
   logic       push;
   logic       issue;

   assign wr_req   = '{data: in_data, amt: in_amt};
   assign in_ready = !full;
   assign push     = in_valid && in_ready && !flush;
   assign issue    = !empty && (!out_valid || out_ready) && !flush;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(shift_req_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (push),
      .pop     (issue),
      .wr_data (wr_req),
      .head    (head_req),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // Keep the shifter inputs quiet while the FIFO holds nothing valid
   assign sh_a = empty ? '0 : head_req.data;
   assign sh_b = empty ? '0 : head_req.amt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_data  <= sh_o;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_shift_issue_queue.sv
// Randomised bench for shift_issue_queue against a queue-based reference model.
module tb_shift_issue_queue;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [2:0] in_amt = 3'd0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] sh_a;
   logic [2:0] sh_b;
   logic [7:0] sh_o;
   logic [7:0] out_data;
   logic [2:0] count;

   always #5 clk = ~clk;

   assign sh_o = sh_a >> sh_b;

   shift_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .sh_a      (sh_a),
      .sh_b      (sh_b),
      .sh_o      (sh_o),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   typedef struct {
      bit [7:0] data;
      bit [2:0] amt;
   } req_t;

   req_t     mq[$];
   bit       m_valid = 1'b0;
   bit [7:0] m_data  = 8'h00;
   bit       m_push;
   bit       m_issue;
   int       checks = 0;
   int       errors = 0;

   // Reference: a request queue plus one result slot, advanced per rising edge
   task automatic tick();
      @(posedge clk);
      m_push  = 1'b0;
      m_issue = 1'b0;
      if (!rst_n || flush) begin
         mq.delete();
         m_valid = 1'b0;
         if (!rst_n) m_data = 8'h00;
      end else begin
         m_push = in_valid && (mq.size() < DEPTH);
         if (mq.size() > 0 && (!m_valid || out_ready)) begin
            m_data  = mq[0].data >> mq[0].amt;
            m_valid = 1'b1;
            m_issue = 1'b1;
            void'(mq.pop_front());
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (m_push) mq.push_back('{in_data, in_amt});
      end
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_state out_valid=%b count=%0d out_data=%h want 0/0/00", out_valid, count, out_data);
      end
      checks++;
      if (sh_a !== 8'h00 || sh_b !== 3'd0) begin
         errors++;
         $display("FAIL reset_head sh_a=%h sh_b=%0d want 00/0", sh_a, sh_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b want 1", in_ready);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hB4;
      in_amt    = 3'd3;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd1 || sh_a !== 8'hB4 || sh_b !== 3'd3) begin
         errors++;
         $display("FAIL single_edge1 out_valid=%b count=%0d sh_a=%h sh_b=%0d want 0/1/b4/3", out_valid, count, sh_a, sh_b);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h16 || count !== 3'd0) begin
         errors++;
         $display("FAIL single_edge2 out_valid=%b out_data=%h count=%0d want 1/16/0", out_valid, out_data, count);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h16) begin
         errors++;
         $display("FAIL single_drain out_valid=%b out_data=%h want 0/16", out_valid, out_data);
      end
   endtask

   task automatic test_fill_stall();
      int  n = 0;
      int  k;
      bit  sixth_in = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 20 && n < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hFF;
         in_amt   = 3'(n);
         tick();
         if (m_push) n++;
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL fill_accept accepted=%0d want 5", n);
      end
      in_amt = 3'd5;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b1 || out_data !== 8'hFF || m_push) begin
         errors++;
         $display("FAIL fill_stall in_ready=%b count=%0d out_valid=%b out_data=%h want 0/4/1/ff", in_ready, count, out_valid, out_data);
      end
      out_ready = 1'b1;
      k = 1;
      for (int i = 0; i < 12; i++) begin
         in_valid = !sixth_in;
         tick();
         if (m_push) sixth_in = 1'b1;
         if (m_issue) begin
            checks++;
            if (out_data !== (8'hFF >> k)) begin
               errors++;
               $display("FAIL fill_order idx=%0d got=%h want=%h", k, out_data, 8'hFF >> k);
            end
            k++;
         end
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || count !== 3'(mq.size())) begin
            errors++;
            $display("FAIL fill_drain cyc=%0d out_valid=%b/%b out_data=%h/%h count=%0d/%0d", i, out_valid, m_valid, out_data, m_data, count, mq.size());
         end
      end
      in_valid = 1'b0;
      checks++;
      if (k != 6) begin
         errors++;
         $display("FAIL fill_total results=%0d want 6", k);
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         in_valid = (i < 16);
         in_data  = 8'h80;
         in_amt   = 3'(i % 8);
         tick();
         if (i >= 1 && i <= 16) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== (8'h80 >> ((i - 1) % 8))) begin
               errors++;
               $display("FAIL stream idx=%0d out_valid=%b out_data=%h want 1/%h", i - 1, out_valid, out_data, 8'h80 >> ((i - 1) % 8));
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL stream_end out_valid=%b count=%0d want 0/0", out_valid, count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_a;
      logic [2:0] exp_b;
      for (int i = 0; i < 48; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         in_amt    = 3'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         if (i >= 40) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         tick();
         exp_a = (mq.size() > 0) ? mq[0].data : 8'h00;
         exp_b = (mq.size() > 0) ? mq[0].amt : 3'd0;
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || count !== 3'(mq.size())
             || in_ready !== (mq.size() != DEPTH) || sh_a !== exp_a || sh_b !== exp_b) begin
            errors++;
            $display("FAIL wrap cyc=%0d out_valid=%b/%b out_data=%h/%h count=%0d/%0d in_ready=%b sh=%h,%0d/%h,%0d",
                     i, out_valid, m_valid, out_data, m_data, count, mq.size(), in_ready, sh_a, sh_b, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_flush();
      logic [7:0] held;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_amt   = 3'($urandom);
         tick();
      end
      checks++;
      if (count !== 3'd3 || out_valid !== 1'b1 || out_data !== m_data) begin
         errors++;
         $display("FAIL flush_setup count=%0d out_valid=%b out_data=%h want 3/1/%h", count, out_valid, out_data, m_data);
      end
      held     = out_data;
      flush    = 1'b1;
      in_data  = 8'hAA;
      in_amt   = 3'd1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== held) begin
         errors++;
         $display("FAIL flush_clear count=%0d out_valid=%b in_ready=%b out_data=%h want 0/0/1/%h", count, out_valid, in_ready, out_data, held);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL flush_dropped cyc=%0d out_valid=%b count=%0d want 0/0", i, out_valid, count);
         end
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_amt   = 3'($urandom);
         tick();
      end
      #2;
      rst_n = 1'b0;
      mq.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || sh_a !== 8'h00 || sh_b !== 3'd0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL async_reset out_valid=%b count=%0d sh_a=%h sh_b=%0d out_data=%h want all 0", out_valid, count, sh_a, sh_b, out_data);
      end
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      in_amt    = 3'd2;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd1) begin
         errors++;
         $display("FAIL post_reset_push out_valid=%b count=%0d want 0/1", out_valid, count);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0F || count !== 3'd0) begin
         errors++;
         $display("FAIL post_reset_result out_valid=%b out_data=%h count=%0d want 1/0f/0", out_valid, out_data, count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_fill_stall();
      test_stream();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
